keypad_key_decoder: RTL

- Sits directly downstream of the keypad column scanner and consumes its 20-bit active-low key_data frame (4 columns x 5 rows).
- Debounces the frame and encodes the single pressed key into a 5-bit key code.
- Generates press, auto-repeat and release events with one-cycle pulses for the application logic (display / FND / UART stages).
- Rejects multi-key (ghost) patterns.

---
 rtl/keypad_key_decoder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_key_decoder.sv
// Debounces the 20-bit active-low keypad scanner frame and encodes one pressed key.
// Emits registered press, auto-repeat, release and ghost (multi-key) events.
module keypad_key_decoder #(
  parameter int DEB_CYCLES    = 4,
  parameter int REL_CYCLES    = 3,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 10,
  parameter int REPEAT_PERIOD = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] key_data,
  output logic        key_valid,
  output logic [4:0]  key_code,
  output logic        key_repeat,
  output logic        key_held,
  output logic        key_release,
  output logic        key_ghost
);

  localparam int MAX_DR = (DEB_CYCLES > REL_CYCLES) ? DEB_CYCLES : REL_CYCLES;
  localparam int MAX_RP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAX_P  = (MAX_DR > MAX_RP) ? MAX_DR : MAX_RP;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_CYCLES);
  localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [19:0]      d_r;
  state_t           state_r, state_s;
  logic [4:0]       cand_r, cand_s;
  logic [CNT_W-1:0] deb_cnt_r, deb_cnt_s;
  logic [CNT_W-1:0] rel_cnt_r, rel_cnt_s;
  logic [CNT_W-1:0] rep_cnt_r, rep_cnt_s;
  logic             rep_later_r, rep_later_s;
  logic [4:0]       key_code_r, key_code_s;
  logic             key_valid_r, key_valid_s;
  logic             key_repeat_r, key_repeat_s;
  logic             key_held_r, key_held_s;
  logic             key_release_r, key_release_s;
  logic             key_ghost_r, key_ghost_s;

  logic [1:0]       zero_cnt_s;
  logic [4:0]       zero_idx_s;
  logic             is_single_s;
  logic             is_multi_s;
  logic [4:0]       samp_code_s;
  logic [CNT_W-1:0] rep_inc_s;
  logic [CNT_W-1:0] rel_inc_s;
  logic [CNT_W-1:0] rep_target_s;

  // Classify the registered frame: count zeros (saturating at 2) and locate one.
  always_comb begin
    zero_cnt_s = 2'd0;
    zero_idx_s = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (d_r[i] == 1'b0) begin
        zero_idx_s = 5'(i);
        if (zero_cnt_s == 2'd2) begin
          zero_cnt_s = 2'd2;
        end else begin
          zero_cnt_s = zero_cnt_s + 2'd1;
        end
      end else begin
        zero_idx_s = zero_idx_s;
      end
    end
  end

  assign is_single_s  = (zero_cnt_s == 2'd1);
  assign is_multi_s   = (zero_cnt_s == 2'd2);
  // Bit 19 is column1/row4, which is key 0.
  assign samp_code_s  = 5'd19 - zero_idx_s;
  assign rep_inc_s    = sat_inc(rep_cnt_r);
  assign rel_inc_s    = sat_inc(rel_cnt_r);
  assign rep_target_s = rep_later_r ? REP_NEXT : REP_FIRST;

  // Next-state, counter and event logic.
  always_comb begin
    state_s       = state_r;
    cand_s        = cand_r;
    deb_cnt_s     = deb_cnt_r;
    rel_cnt_s     = rel_cnt_r;
    rep_cnt_s     = rep_cnt_r;
    rep_later_s   = rep_later_r;
    key_code_s    = key_code_r;
    key_valid_s   = 1'b0;
    key_repeat_s  = 1'b0;
    key_release_s = 1'b0;
    key_ghost_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_single_s) begin
          cand_s    = samp_code_s;
          deb_cnt_s = CNT_ONE;
          state_s   = ST_DEBOUNCE;
        end else if (is_multi_s) begin
          key_ghost_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (is_single_s && (samp_code_s == cand_r)) begin
          if (deb_cnt_r == DEB_LAST) begin
            state_s     = ST_PRESSED;
            key_code_s  = cand_r;
            key_valid_s = 1'b1;
            rep_cnt_s   = CNT_ZERO;
            rel_cnt_s   = CNT_ZERO;
            rep_later_s = 1'b0;
          end else begin
            deb_cnt_s = sat_inc(deb_cnt_r);
          end
        end else begin
          state_s   = ST_IDLE;
          deb_cnt_s = CNT_ZERO;
        end
      end
      ST_PRESSED: begin
        if (is_single_s && (samp_code_s == key_code_r)) begin
          rel_cnt_s = CNT_ZERO;
          if ((REPEAT_EN != 0) && (rep_inc_s == rep_target_s)) begin
            key_valid_s  = 1'b1;
            key_repeat_s = 1'b1;
            rep_cnt_s    = CNT_ZERO;
            rep_later_s  = 1'b1;
          end else if (REPEAT_EN != 0) begin
            rep_cnt_s = rep_inc_s;
          end else begin
            rep_cnt_s = rep_cnt_r;
          end
        end else begin
          // Mismatch: repeat count is frozen so a glitch resumes the cadence.
          if (rel_inc_s == REL_LAST) begin
            key_release_s = 1'b1;
            state_s       = ST_IDLE;
            rel_cnt_s     = CNT_ZERO;
            rep_cnt_s     = CNT_ZERO;
            deb_cnt_s     = CNT_ZERO;
          end else begin
            rel_cnt_s = rel_inc_s;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    key_held_s = (state_s == ST_PRESSED);
  end

  // Input register, FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r           <= 20'hFFFFF;
      state_r       <= ST_IDLE;
      cand_r        <= 5'd0;
      deb_cnt_r     <= CNT_ZERO;
      rel_cnt_r     <= CNT_ZERO;
      rep_cnt_r     <= CNT_ZERO;
      rep_later_r   <= 1'b0;
      key_code_r    <= 5'd0;
      key_valid_r   <= 1'b0;
      key_repeat_r  <= 1'b0;
      key_held_r    <= 1'b0;
      key_release_r <= 1'b0;
      key_ghost_r   <= 1'b0;
    end else begin
      d_r           <= key_data;
      state_r       <= state_s;
      cand_r        <= cand_s;
      deb_cnt_r     <= deb_cnt_s;
      rel_cnt_r     <= rel_cnt_s;
      rep_cnt_r     <= rep_cnt_s;
      rep_later_r   <= rep_later_s;
      key_code_r    <= key_code_s;
      key_valid_r   <= key_valid_s;
      key_repeat_r  <= key_repeat_s;
      key_held_r    <= key_held_s;
      key_release_r <= key_release_s;
      key_ghost_r   <= key_ghost_s;
    end
  end

  assign key_valid   = key_valid_r;
  assign key_code    = key_code_r;
  assign key_repeat  = key_repeat_r;
  assign key_held    = key_held_r;
  assign key_release = key_release_r;
  assign key_ghost   = key_ghost_r;

endmodule
